// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-master memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
    } mem_req_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master-side and memory-side signal bundle of the arbiter
interface mem_arbiter_if;

    logic        m0_req_i;
    logic        m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_wd_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_rd_o;
    logic        m0_ready_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_wd_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_rd_o;
    logic        m1_ready_o;
    logic        m1_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    // Arbiter side
    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_wd_i, m0_addr_i,
        output m0_rd_o, m0_ready_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_wd_i, m1_addr_i,
        output m1_rd_o, m1_ready_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_wd_o, mem_addr_o,
        input  mem_rd_i, mem_ready_i
    );

    // Environment side: requesting masters plus the external memory
    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_wd_i, m0_addr_i,
        input  m0_rd_o, m0_ready_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_wd_i, m1_addr_i,
        input  m1_rd_o, m1_ready_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_wd_o, mem_addr_o,
        output mem_rd_i, mem_ready_i
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational two-way round-robin winner selection
module mem_arb_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    // On a tie the master that did not win last time goes first
    assign winner_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one external memory port between two masters with timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    mem_req_t         req_q, req_d;
    logic [31:0]      rd0_q, rd0_d;
    logic [31:0]      rd1_q, rd1_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pick_valid;
    logic pick_winner;

    mem_arb_rr_pick u_pick (
        .req0_i       (bus.m0_req_i),
        .req1_i       (bus.m1_req_i),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            req_q        <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    req_d.we     = pick_winner ? bus.m1_we_i   : bus.m0_we_i;
                    req_d.be     = pick_winner ? bus.m1_be_i   : bus.m0_be_i;
                    req_d.wd     = pick_winner ? bus.m1_wd_i   : bus.m0_wd_i;
                    req_d.addr   = pick_winner ? bus.m1_addr_i : bus.m0_addr_i;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // A ready on the limit cycle still counts as success
                if (bus.mem_ready_i) begin
                    if (grant_q) rd1_d = bus.mem_rd_i;
                    else         rd0_d = bus.mem_rd_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    if (grant_q) rd1_d = ERR_RDATA;
                    else         rd0_d = ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic resp0;
    logic resp1;

    assign resp0 = (state_q == RESP) && !grant_q;
    assign resp1 = (state_q == RESP) &&  grant_q;

    assign bus.mem_req_o  = (state_q == BUSY);
    assign bus.mem_we_o   = req_q.we;
    assign bus.mem_be_o   = req_q.be;
    assign bus.mem_wd_o   = req_q.wd;
    assign bus.mem_addr_o = req_q.addr;

    assign bus.m0_ready_o = resp0;
    assign bus.m0_err_o   = resp0 && err_q;
    assign bus.m0_rd_o    = rd0_q;
    assign bus.m1_ready_o = resp1;
    assign bus.m1_err_o   = resp1 && err_q;
    assign bus.m1_rd_o    = rd1_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single external data-memory port (req/we/be/wd/addr/rd/ready) between master 0 (core LSU) and master 1 (DMA/debug loader). It sits between the masters' memory-side ports and `ext_mem`. It latches the winning request, holds it on the memory port until `ready`, and returns read data with a one-cycle ready pulse. A timeout terminates hung accesses with an error pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max BUSY cycles waiting for `mem_ready_i`; 0 disables timeout
- `ERR_RDATA`, 32'h0000_0000: read data returned on timeout

Ports (`mX_` is one set per master, X = 0,1):
- `clk_i` in 1: single clock, all state on rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `mX_req_i` in 1: access request, held until `mX_ready_o`
- `mX_we_i` in 1: 1 = write
- `mX_be_i` in 4: byte enables
- `mX_wd_i` in 32: write data
- `mX_addr_i` in 32: byte address
- `mX_rd_o` out 32: read data, valid with `mX_ready_o`
- `mX_ready_o` out 1: one-cycle completion pulse
- `mX_err_o` out 1: one-cycle timeout pulse, coincident with `mX_ready_o`
- `mem_req_o` out 1: to `ext_mem` `mem_req_i`
- `mem_we_o` out 1: to `ext_mem` `write_enable_i`
- `mem_be_o` out 4: to `ext_mem` `byte_enable_i`
- `mem_wd_o` out 32: to `ext_mem` `write_data_i`
- `mem_addr_o` out 32: to `ext_mem` `addr_i`
- `mem_rd_i` in 32: from `ext_mem` `read_data_o`
- `mem_ready_i` in 1: from `ext_mem` `ready_o`

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: sample `m0_req_i`/`m1_req_i`.
    - If either is high, pick a winner: a single requester wins; if both request, the master not in `last_grant` wins.
    - Latch the winner's we/be/wd/addr into the request register, set `grant` and `last_grant` to the winner, clear the timeout counter, and go to BUSY.
  - BUSY: `mem_req_o`=1, driven from the latched request only; master inputs are ignored.
    - On `mem_ready_i`=1: capture `mem_rd_i` (reads and writes alike), go to RESP.
    - Else, when `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1: capture `ERR_RDATA`, set the error flag, go to RESP.
    - Otherwise the counter increments.
  - RESP:
    - For the granted master: `mX_ready_o`=1 for exactly this cycle and `mX_rd_o`= captured data; `mX_err_o`= error flag.
    - `mem_req_o`=0. Next state is IDLE.
- `mX_rd_o` holds its last captured value between accesses. The other master's outputs stay 0/held.
- A master must drop `req` in the cycle after its ready pulse unless it issues a new access. A `req` seen in IDLE is always treated as a new access.
- Non-granted master waits with `req` high; starvation-free: it wins the next arbitration.
- Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`, minimum 1; no wrap is reachable.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `last_grant`=1 (master 0 wins the first tie), counter=0.
  - Request and data registers are 0; every output is 0.
- Reset asserted in BUSY/RESP aborts the access. No ready pulse is issued, and `mem_req_o` drops immediately.
- Latency, req seen in IDLE at cycle t:
  - `mem_req_o` rises at t+1.
  - With `mem_ready_i` at t+1+k (k≥0), the ready pulse occurs at t+2+k.
  - Minimum request-to-ready latency is 2 cycles.
- Back-to-back accesses: one IDLE cycle between RESP and the next BUSY. Throughput is 1 access per 3 cycles when memory responds immediately.
- Timeout: the ready+err pulse occurs at t+1+`TIMEOUT_CYCLES`.
- `mem_ready_i` outside BUSY is ignored.
- A `mem_ready_i` arriving in the same cycle the counter hits the limit counts as success (ready wins).

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t`
  - `typedef struct packed` `mem_req_t` {we, be[3:0], wd[31:0], addr[31:0]}
  - constant `DEFAULT_TIMEOUT`=255
- Sub-module `mem_arb_rr_pick`: combinational two-way round-robin picker. Inputs are the two reqs and `last_grant`; outputs are `valid` and `winner`.
- Top module: FSM, request latch, response capture, timeout counter.

## Test plan
- Single master 0 write, addr 0x10, wd 0xCAFEBABE, be 4'hF, memory ready immediately:
  - `mem_req_o` high 1 cycle with the latched values.
  - `m0_ready_o` pulse 2 cycles after req; `m1_*` stay 0.
- Both masters request in the same cycle after reset, 2 reads each, held:
  - Grant order is m0, m1, m0, m1.
  - Each `mX_rd_o` matches the memory contents at its own address.
- Master 1 read with memory ready delayed 5 cycles:
  - Ready pulse at t+7 with correct data.
  - A master 0 request raised mid-access is granted only after master 1's RESP.
- `TIMEOUT_CYCLES`=4 and memory never ready:
  - `m0_ready_o` and `m0_err_o` pulse together at t+5, with `m0_rd_o`=`ERR_RDATA`.
  - The FSM returns to IDLE and the next access succeeds.
- Reset asserted in BUSY mid-access:
  - All outputs are 0 immediately and no ready pulse is issued.
  - After release, a simultaneous request is won by master 0.
